// File: rtl/spi_mem_bridge_if.sv
// CPU-side byte memory request/response bus of the SPI SRAM bridge.
// The CPU drives the master side; the bridge takes the slave side.
interface spi_mem_bridge_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8
);
  logic                  reqValid;
  logic                  reqReady;
  logic [ADDR_WIDTH-1:0] memReqBus;
  logic                  memWriteReq;
  logic [DATA_WIDTH-1:0] memWriteData;
  logic                  respValid;
  logic [DATA_WIDTH-1:0] memReadBus;

  modport master (
    output reqValid, memReqBus, memWriteReq, memWriteData,
    input  reqReady, respValid, memReadBus
  );

  modport slave (
    input  reqValid, memReqBus, memWriteReq, memWriteData,
    output reqReady, respValid, memReadBus
  );
endinterface

// File: rtl/spi_mem_bridge.sv
// Single-byte SPI SRAM responder: one READ/WRITE frame {cmd, addr16, data} per request,
// SPI mode 0 at clk/2, completion signalled by a one-cycle respValid pulse.
module spi_mem_bridge #(
  parameter int         ADDR_WIDTH = 15,
  parameter int         DATA_WIDTH = 8,
  parameter logic [7:0] READ_CMD   = 8'h03,
  parameter logic [7:0] WRITE_CMD  = 8'h02
) (
  input  logic            clk,
  input  logic            reset,
  spi_mem_bridge_if.slave bus,
  output logic            spiCs_n,
  output logic            spiSck,
  output logic            spiMosi,
  input  logic            spiMiso
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t                state_r, state_s;
  logic [31:0]           tx_r, tx_s;
  logic [DATA_WIDTH-1:0] rx_r, rx_s, rx_shift_s;
  logic [4:0]            bit_cnt_r, bit_cnt_s;
  logic                  phase_r, phase_s;
  logic                  is_read_r, is_read_s;
  logic                  cs_n_r, cs_n_s;
  logic                  sck_r, sck_s;
  logic                  mosi_r, mosi_s;
  logic                  resp_r, resp_s;
  logic [DATA_WIDTH-1:0] rdata_r, rdata_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic [15:0]           addr_ext_s;

  assign addr_s     = bus.memReqBus;
  assign addr_ext_s = 16'(addr_s);

  // Next-state, datapath and next-output logic; pins are registered from the next state.
  always_comb begin
    state_s    = state_r;
    tx_s       = tx_r;
    rx_s       = rx_r;
    bit_cnt_s  = bit_cnt_r;
    phase_s    = phase_r;
    is_read_s  = is_read_r;
    rdata_s    = rdata_r;
    rx_shift_s = {rx_r[DATA_WIDTH-2:0], spiMiso};

    case (state_r)
      ST_IDLE: begin
        if (bus.reqValid) begin
          state_s   = ST_SHIFT;
          tx_s      = {(bus.memWriteReq ? WRITE_CMD : READ_CMD), addr_ext_s,
                       (bus.memWriteReq ? bus.memWriteData : {DATA_WIDTH{1'b0}})};
          is_read_s = ~bus.memWriteReq;
          bit_cnt_s = 5'd0;
          phase_s   = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (!phase_r) begin
          phase_s = 1'b1;
        end else begin
          // Rising-edge half done: sample MISO, advance MOSI, count the bit.
          phase_s   = 1'b0;
          rx_s      = rx_shift_s;
          tx_s      = {tx_r[30:0], 1'b0};
          bit_cnt_s = bit_cnt_r + 5'd1;
          if (bit_cnt_r == 5'd31) begin
            state_s = ST_FINISH;
            if (is_read_r) begin
              rdata_s = rx_shift_s;
            end else begin
              rdata_s = rdata_r;
            end
          end else begin
            state_s = ST_SHIFT;
          end
        end
      end
      ST_FINISH: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    cs_n_s = (state_s != ST_SHIFT);
    sck_s  = (state_s == ST_SHIFT) && phase_s;
    mosi_s = (state_s == ST_SHIFT) ? tx_s[31] : 1'b0;
    resp_s = (state_s == ST_FINISH);
  end

  // State, shift registers and registered pins; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      tx_r      <= 32'h0000_0000;
      rx_r      <= {DATA_WIDTH{1'b0}};
      bit_cnt_r <= 5'd0;
      phase_r   <= 1'b0;
      is_read_r <= 1'b0;
      cs_n_r    <= 1'b1;
      sck_r     <= 1'b0;
      mosi_r    <= 1'b0;
      resp_r    <= 1'b0;
      rdata_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r   <= state_s;
      tx_r      <= tx_s;
      rx_r      <= rx_s;
      bit_cnt_r <= bit_cnt_s;
      phase_r   <= phase_s;
      is_read_r <= is_read_s;
      cs_n_r    <= cs_n_s;
      sck_r     <= sck_s;
      mosi_r    <= mosi_s;
      resp_r    <= resp_s;
      rdata_r   <= rdata_s;
    end
  end

  assign bus.reqReady   = (state_r == ST_IDLE);
  assign bus.respValid  = resp_r;
  assign bus.memReadBus = rdata_r;
  assign spiCs_n        = cs_n_r;
  assign spiSck         = sck_r;
  assign spiMosi        = mosi_r;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Bench for spi_mem_bridge: SPI SRAM model, cycle-count reference model compared every
// cycle, directed scenarios with literal expectations and a randomized request phase.
module tb_spi_mem_bridge;
  localparam int AW = 15;
  localparam int DW = 8;

  logic clk;
  logic reset;
  logic spiCs_n, spiSck, spiMosi, spiMiso;

  int checks;
  int failures;
  int cyc;
  bit check_en;

  spi_mem_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  spi_mem_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_CMD(8'h03), .WRITE_CMD(8'h02)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .spiCs_n(spiCs_n), .spiSck(spiSck), .spiMosi(spiMosi), .spiMiso(spiMiso)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- SPI SRAM model (mode 0, 64 KiB) ----------------
  logic [7:0]  sram [65536];
  logic        s_init;
  logic        s_prev_cs, s_prev_sck, s_is_rd;
  int          s_bits;
  int          frames;
  logic [31:0] s_frame, last_frame;
  logic [7:0]  s_rd;
  logic        pre_en;
  logic [15:0] pre_addr;
  logic [7:0]  pre_data;

  always @(negedge clk) begin
    if (s_init !== 1'b1) begin
      for (int i = 0; i < 65536; i++) sram[i] <= 8'(i ^ (i >> 8) ^ 32'h5A);
      s_init     <= 1'b1;
      s_prev_cs  <= 1'b1;
      s_prev_sck <= 1'b0;
      s_bits     <= 0;
      s_frame    <= '0;
      last_frame <= '0;
      s_rd       <= '0;
      s_is_rd    <= 1'b0;
      spiMiso    <= 1'b0;
    end else begin
      if (pre_en === 1'b1) sram[pre_addr] <= pre_data;
      if (spiCs_n) begin
        if (!s_prev_cs && s_bits == 32) begin
          last_frame <= s_frame;
          frames     <= frames + 1;
          if (s_frame[31:24] == 8'h02) sram[s_frame[23:8]] <= s_frame[7:0];
        end
        s_bits <= 0;
      end else if (s_prev_cs) begin
        spiMiso <= 1'($urandom);
      end else if (spiSck && !s_prev_sck) begin
        s_frame <= {s_frame[30:0], spiMosi};
        s_bits  <= s_bits + 1;
      end else if (!spiSck && s_prev_sck) begin
        if (s_bits == 24) begin
          s_is_rd <= (s_frame[23:16] == 8'h03);
          s_rd    <= sram[s_frame[15:0]];
          if (s_frame[23:16] == 8'h03) spiMiso <= sram[s_frame[15:0]][7];
          else                         spiMiso <= 1'($urandom);
        end else if (s_bits > 24 && s_bits < 32 && s_is_rd) begin
          spiMiso <= s_rd[31 - s_bits];
        end else begin
          spiMiso <= 1'($urandom);
        end
      end
      s_prev_cs  <= spiCs_n;
      s_prev_sck <= spiSck;
    end
  end

  // ---------------- reference model: position within a 66-cycle transaction ----------------
  int          m_cnt;
  logic [31:0] m_frame;
  logic        m_is_rd;
  logic [7:0]  m_rd_val, m_rd;
  logic        m_busy;

  assign m_busy = (m_cnt >= 1) && (m_cnt <= 64);

  always @(posedge clk) begin
    if (!reset) begin
      m_cnt <= 0;
      m_rd  <= 8'h00;
    end else if (m_cnt == 0) begin
      if (bus.reqValid) begin
        m_cnt    <= 1;
        m_frame  <= {(bus.memWriteReq ? 8'h02 : 8'h03), 16'(bus.memReqBus),
                     (bus.memWriteReq ? bus.memWriteData : 8'h00)};
        m_is_rd  <= !bus.memWriteReq;
        m_rd_val <= sram[16'(bus.memReqBus)];
      end
    end else begin
      if (m_cnt == 64 && m_is_rd) m_rd <= m_rd_val;
      m_cnt <= (m_cnt == 65) ? 0 : m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("reqReady",   32'(bus.reqReady),   32'(m_cnt == 0));
      check("respValid",  32'(bus.respValid),  32'(m_cnt == 65));
      check("spiCs_n",    32'(spiCs_n),        32'(!m_busy));
      check("spiSck",     32'(spiSck),         32'(m_busy && (m_cnt % 2 == 0)));
      check("spiMosi",    32'(spiMosi),        32'(m_busy ? m_frame[31 - (m_cnt - 1) / 2] : 1'b0));
      check("memReadBus", 32'(bus.memReadBus), 32'(m_rd));
    end
  end

  int resp_cnt;
  int resp_cyc[$];

  always @(negedge clk) begin
    if (bus.respValid === 1'b1) begin
      resp_cnt <= resp_cnt + 1;
      resp_cyc.push_back(cyc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_cnt != 0 && n < 200) begin
      step();
      n++;
    end
    check("idle_timeout", 32'(m_cnt != 0), 32'd0);
  endtask

  task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [7:0] d);
    wait_idle();
    bus.reqValid     = 1'b1;
    bus.memWriteReq  = wr;
    bus.memReqBus    = a;
    bus.memWriteData = d;
    step();
    bus.reqValid     = 1'b0;
    bus.memWriteReq  = 1'($urandom);
    bus.memReqBus    = AW'($urandom);
    bus.memWriteData = 8'($urandom);
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(negedge clk);
    #1;
    pre_en   = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int frames0, resp0;
    reset            = 1'b0;
    pre_en           = 1'b0;
    bus.reqValid     = 1'b0;
    bus.memWriteReq  = 1'b0;
    bus.memReqBus    = '0;
    bus.memWriteData = '0;
    repeat (3) step();
    reset    = 1'b1;
    check_en = 1'b1;

    check("rst_reqReady",  32'(bus.reqReady),   32'd1);
    check("rst_respValid", 32'(bus.respValid),  32'd0);
    check("rst_cs",        32'(spiCs_n),        32'd1);
    check("rst_sck",       32'(spiSck),         32'd0);
    check("rst_mosi",      32'(spiMosi),        32'd0);
    check("rst_rdata",     32'(bus.memReadBus), 32'd0);

    // Test 1: read 0x1234 returning 0xA5
    preload(16'h1234, 8'hA5);
    do_req(1'b0, 15'h1234, 8'h00);
    wait_idle();
    check("t1_model_frame", m_frame,    32'h0312_3400);
    check("t1_spi_frame",   last_frame, 32'h0312_3400);
    check("t1_rdata",       32'(bus.memReadBus), 32'h0000_00A5);

    // Test 2: write 0x3C to 0x7FFF, read it back
    do_req(1'b1, 15'h7FFF, 8'h3C);
    wait_idle();
    check("t2_spi_frame", last_frame, 32'h027F_FF3C);
    check("t2_rdata_kept", 32'(bus.memReadBus), 32'h0000_00A5);
    do_req(1'b0, 15'h7FFF, 8'h00);
    wait_idle();
    check("t2_readback", 32'(bus.memReadBus), 32'h0000_003C);

    // Test 3: reqValid held high with a wandering address
    frames0          = frames;
    bus.reqValid     = 1'b1;
    bus.memWriteReq  = 1'b0;
    bus.memReqBus    = 15'h0ABC;
    step();
    for (int i = 1; i < 66; i++) begin
      bus.memReqBus = AW'($urandom);
      step();
    end
    bus.memReqBus = 15'h1555;
    step();
    bus.reqValid = 1'b0;
    wait_idle();
    check("t3_frames", 32'(frames - frames0), 32'd2);
    check("t3_second_frame", last_frame, 32'h0315_5500);

    // Test 6: back-to-back reads of 0x0000 and 0x0001
    preload(16'h0000, 8'h11);
    preload(16'h0001, 8'h22);
    do_req(1'b0, 15'h0000, 8'h00);
    repeat (65) step();
    check("t6_first", 32'(bus.memReadBus), 32'h0000_0011);
    do_req(1'b0, 15'h0001, 8'h00);
    wait_idle();
    check("t6_second", 32'(bus.memReadBus), 32'h0000_0022);
    check("t6_gap", 32'(resp_cyc[$] - resp_cyc[$-1]), 32'd66);

    // Randomized mix of reads and writes with idle gaps
    for (int t = 0; t < 25; t++) begin
      do_req(1'($urandom), AW'($urandom), 8'($urandom));
      wait_idle();
      repeat ($urandom_range(0, 3)) step();
    end

    // Test 4: reset at cycle 20 of a read
    do_req(1'b0, 15'h0456, 8'h00);
    resp0 = resp_cnt;
    repeat (19) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("t4_cs",       32'(spiCs_n),        32'd1);
    check("t4_sck",      32'(spiSck),         32'd0);
    check("t4_reqReady", 32'(bus.reqReady),   32'd1);
    check("t4_rdata",    32'(bus.memReadBus), 32'd0);

    // Test 5: quiet idle after reset
    for (int i = 0; i < 10; i++) begin
      step();
      check("t5_cs",   32'(spiCs_n),       32'd1);
      check("t5_sck",  32'(spiSck),        32'd0);
      check("t5_mosi", 32'(spiMosi),       32'd0);
      check("t5_resp", 32'(bus.respValid), 32'd0);
    end
    check("t4_no_resp", 32'(resp_cnt - resp0), 32'd0);

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_mem_bridge.md
Name: spi_mem_bridge

Overview:
Memory-side responder for the CPU's byte memory interface. It accepts one read or write request at a time through a valid/ready handshake and runs a single-byte SPI SRAM transaction (mode 0, 23LC512-style READ/WRITE command, 16-bit address). Read data is returned with a one-cycle response strobe. The CPU's memory address, write request and read data buses connect to it, and the SPI pins go to the external SRAM.

Parameters:
ADDR_WIDTH, 15, request address width; must be <=16; zero-extended to 16 bits on SPI
DATA_WIDTH, 8, data width; fixed at 8 (one SPI data byte)
READ_CMD, 8'h03, SPI read opcode
WRITE_CMD, 8'h02, SPI write opcode

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
reqValid  input  1  request present this cycle
reqReady  output  1  bridge idle and able to accept a request
memReqBus  input  ADDR_WIDTH  request byte address
memWriteReq  input  1  1 = write, 0 = read; qualified by reqValid
memWriteData  input  DATA_WIDTH  write byte; qualified by reqValid & memWriteReq
respValid  output  1  one-cycle pulse marking transaction completion
memReadBus  output  DATA_WIDTH  last read byte; holds its value between reads
spiCs_n  output  1  SRAM chip select, active low
spiSck  output  1  SPI clock, clk/2, idles low
spiMosi  output  1  serial data to SRAM, MSB first
spiMiso  input  1  serial data from SRAM

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE, reqReady=1, respValid=0, memReadBus=0, spiCs_n=1, spiSck=0, spiMosi=0, and all counters and shift registers cleared.
- Reset mid-transaction: the transaction is aborted. The cycle after the reset edge shows spiCs_n=1 and spiSck=0, and no respValid is issued.
- All outputs are registered, except reqReady = (state==IDLE).
- State IDLE:
  - spiCs_n=1, spiSck=0.
  - On a clk edge with reqValid & reqReady:
    - Latch the request.
    - Load the 32-bit TX shift register with {cmd, 16-bit zero-extended address, wdata}. cmd is WRITE_CMD or READ_CMD. wdata is memWriteData for writes and 8'h00 for reads.
    - Clear the bit counter and go to SHIFT.
- State SHIFT (exactly 64 cycles; 32 bits x 2 phases):
  - spiCs_n=0.
  - Phase 0 cycle: spiSck=0, spiMosi=TX[31].
  - Phase 1 cycle: spiSck=1, spiMosi unchanged.
  - At the clk edge ending phase 1: sample spiMiso into the 8-bit RX shift register (shifted in at LSB), shift TX left by one, and increment the bit counter.
  - After bit 31's phase 1, go to FINISH.
- State FINISH (1 cycle):
  - spiCs_n=1, spiSck=0, respValid=1.
  - For reads, memReadBus = RX (the last 8 sampled bits, first sampled = MSB), updated at the edge entering FINISH.
  - For writes, memReadBus is unchanged.
  - Next state is IDLE.
- Latency: the handshake edge is cycle 0. spiCs_n is low for cycles 1..64, respValid is high in cycle 65, and reqReady is high again in cycle 66. Back-to-back requests therefore take 66 cycles each.
- Request inputs are ignored while reqReady=0. Changes to memReqBus, memWriteReq or memWriteData mid-transaction do not affect the transaction in flight.
- Address 0x7FFF is sent as 16'h7FFF (bit 15 is always 0 for ADDR_WIDTH=15). No address wrap handling is done in the bridge.
- spiMiso is ignored outside phase-1 sample edges, and during the cmd/addr bits it only shifts through RX. Only the final 8 samples are retained.

Test Plan:
1. Read 0x1234 (reqValid=1, memWriteReq=0) with the SRAM model driving 0xA5 in the data byte -> MOSI bytes 0x03,0x12,0x34,0x00 on rising SCK; spiCs_n low for exactly 64 clks; respValid=1 for one cycle at cycle 65; memReadBus=0xA5.
2. Write 0x3C to 0x7FFF -> MOSI bytes 0x02,0x7F,0xFF,0x3C; respValid pulses at cycle 65; memReadBus keeps its prior value (0xA5 from test 1); a follow-up read of 0x7FFF from the model returns 0x3C.
3. Hold reqValid=1 with a changing address throughout a transaction -> reqReady=0 cycles 1..65; only the first address appears on MOSI; the next request is accepted at cycle 66 and its spiCs_n falls at cycle 67.
4. Assert reset=0 at cycle 20 of a read -> next cycle spiCs_n=1, spiSck=0, reqReady=1; respValid never pulses; memReadBus=0.
5. Post-reset idle for 10 cycles with reqValid=0 -> spiCs_n=1, spiSck=0, spiMosi=0, respValid=0 constant.
6. Back-to-back reads of 0x0000 then 0x0001 with the model returning 0x11 then 0x22 -> two respValid pulses 66 cycles apart; memReadBus=0x11 then 0x22.
